// File: rtl/io_input_debounce_reg_if.sv
// Purpose: CPU-side read bus of the I/O input stage (address, read strobe, read data).
// Latency: read data is combinational from the addressed register.
// Backpressure: none; the stage always answers in the same cycle.
//
// Signals:
//   addr            CPU byte address (only addr[7:2] is decoded by the slave)
//   read_io_enable  CPU read strobe for I/O space (gates read-to-clear only)
//   io_read_data    read data for the addressed register
interface io_input_debounce_reg_if;
    logic [31:0] addr;
    logic        read_io_enable;
    logic [31:0] io_read_data;

    modport master (
        output addr,
        output read_io_enable,
        input  io_read_data
    );

    modport slave (
        input  addr,
        input  read_io_enable,
        output io_read_data
    );
endinterface

// File: rtl/io_input_debounce_reg.sv
// Purpose: synchronise + debounce 8 switches and 4 active-low keys; memory-mapped status, sticky key events, tick counter.
// Latency: a steady raw change reaches in_port/key_pressed DEB_CYCLES+2 edges after first sampled; reads are combinational.
// Backpressure: none; reads are always accepted, a read of the event register clears it on the same edge.
//
// Ports:
//   io_clk       I/O clock, all state on the rising edge
//   clrn         asynchronous active-low reset
//   bus          CPU read bus (slave): addr, read_io_enable in; io_read_data out
//   sw_raw       raw switch levels, asynchronous
//   key_raw_n    raw push keys, active-low, asynchronous
//   in_port      debounced switch byte
//   key_pressed  debounced key levels, active-high
//   key_event    sticky press-event flags (cleared by reading 0x88)
module io_input_debounce_reg #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic                    io_clk,
    input  logic                    clrn,
    io_input_debounce_reg_if.slave  bus,
    input  logic [7:0]              sw_raw,
    input  logic [3:0]              key_raw_n,
    output logic [7:0]              in_port,
    output logic [3:0]              key_pressed,
    output logic [3:0]              key_event
);

    // Switches occupy bits [7:0], keys bits [11:8] of one shared debounce lane.
    localparam int              NB       = 12;
    // Switches rest at 0; keys rest at released (raw 1) so no event fires at reset exit.
    localparam logic [NB-1:0]   RST_LVL  = {4'hF, 8'h00};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [5:0] REG_SW   = 6'b100000;
    localparam logic [5:0] REG_KEY  = 6'b100001;
    localparam logic [5:0] REG_EVT  = 6'b100010;
    localparam logic [5:0] REG_TICK = 6'b100011;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    s1;
    logic [NB-1:0]    s2;
    logic [NB-1:0]    deb;
    logic [NB-1:0]    deb_nxt;
    logic [CNT_W-1:0] cnt     [NB];
    logic [CNT_W-1:0] cnt_nxt [NB];
    logic [3:0]       press;
    logic             rd_clr;
    logic [31:0]      tick;
    logic [5:0]       reg_sel;
    logic             unused_addr;

    assign raw     = {key_raw_n, sw_raw};
    assign reg_sel = bus.addr[7:2];

    // Only addr[7:2] selects a register; the remaining bits are don't-care.
    assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

    // Two-flop synchroniser; only s2 is trusted downstream.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            s1 <= RST_LVL;
            s2 <= RST_LVL;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Per-bit debounce: the counter measures how long s2 has disagreed with
    // the accepted level; any agreement restarts it, so short bounces never win.
    always_comb begin
        deb_nxt = deb;
        for (int i = 0; i < NB; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != deb[i]) begin
                if (cnt[i] == DEB_LAST) begin
                    deb_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            deb <= RST_LVL;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb <= deb_nxt;
            for (int i = 0; i < NB; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Debounced key goes released (1) -> pressed (0) on this edge.
    assign press  = deb[11:8] & ~deb_nxt[11:8];
    assign rd_clr = bus.read_io_enable && (reg_sel == REG_EVT);

    // Set beats clear: a press landing on the clearing edge survives.
    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            key_event <= '0;
        end else begin
            key_event <= (rd_clr ? 4'b0000 : key_event) | press;
        end
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            tick <= '0;
        end else begin
            tick <= tick + 32'd1;
        end
    end

    assign in_port     = deb[7:0];
    assign key_pressed = ~deb[11:8];

    always_comb begin
        bus.io_read_data = '0;
        case (reg_sel)
            REG_SW:   bus.io_read_data = {24'b0, in_port};
            REG_KEY:  bus.io_read_data = {28'b0, key_pressed};
            REG_EVT:  bus.io_read_data = {28'b0, key_event};
            REG_TICK: bus.io_read_data = tick;
            default:  bus.io_read_data = '0;
        endcase
    end

endmodule

// File: tb/tb_io_input_debounce_reg.sv
// Purpose: self-checking bench for io_input_debounce_reg with a window-based reference model.
// Latency: model predicts every output each cycle; directed cases plus a random phase.
// Backpressure: n/a.
module tb_io_input_debounce_reg;

    localparam int DEB = 4;

    logic        io_clk;
    logic        clrn;
    logic [7:0]  sw_raw;
    logic [3:0]  key_raw_n;
    logic [7:0]  in_port;
    logic [3:0]  key_pressed;
    logic [3:0]  key_event;

    io_input_debounce_reg_if bus();

    io_input_debounce_reg #(
        .DEB_CYCLES (DEB),
        .CNT_W      (4)
    ) dut (
        .io_clk      (io_clk),
        .clrn        (clrn),
        .bus         (bus),
        .sw_raw      (sw_raw),
        .key_raw_n   (key_raw_n),
        .in_port     (in_port),
        .key_pressed (key_pressed),
        .key_event   (key_event)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state: accepted raw levels {keys_n, sw}, events, tick,
    // and the history of raw samples taken at each rising edge.
    logic [11:0] m_deb;
    logic [3:0]  m_ev;
    logic [31:0] m_tick;
    logic [11:0] hist[$];

    logic [7:0]  cur_sw;
    logic [3:0]  cur_kn;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_deb  = 12'hF00;
        m_ev   = 4'h0;
        m_tick = 32'd0;
        hist.delete();
        repeat (DEB + 2) hist.push_back(12'hF00);
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[7:2])
            6'h20:   return {24'b0, m_deb[7:0]};
            6'h21:   return {28'b0, ~m_deb[11:8]};
            6'h22:   return {28'b0, m_ev};
            6'h23:   return m_tick;
            default: return 32'd0;
        endcase
    endfunction

    // A bit flips once the DEB most recent synchronised samples (raw values
    // taken two edges earlier) all disagree with the accepted level.
    task automatic model_edge(input logic [11:0] raw, input logic [31:0] a, input logic ren);
        logic [11:0] nd;
        logic [3:0]  pr;
        bit          agree;
        hist.push_back(raw);
        nd = m_deb;
        for (int b = 0; b < 12; b++) begin
            agree = 1'b0;
            for (int k = 0; k < DEB; k++) begin
                if (hist[hist.size() - 3 - k][b] == m_deb[b]) agree = 1'b1;
            end
            if (!agree) nd[b] = ~m_deb[b];
        end
        pr = m_deb[11:8] & ~nd[11:8];
        if (ren && a[7:2] == 6'h22) m_ev = 4'h0;
        m_ev   = m_ev | pr;
        m_deb  = nd;
        m_tick = m_tick + 32'd1;
        while (hist.size() > DEB + 2) void'(hist.pop_front());
    endtask

    // Called at a falling edge: drive, check the whole visible state, clock once.
    task automatic step(input logic [7:0] sw, input logic [3:0] kn, input logic [31:0] a, input logic ren);
        sw_raw             = sw;
        key_raw_n          = kn;
        bus.addr           = a;
        bus.read_io_enable = ren;
        #1;
        check("in_port",     {24'b0, in_port},     {24'b0, m_deb[7:0]});
        check("key_pressed", {28'b0, key_pressed}, {28'b0, ~m_deb[11:8]});
        check("key_event",   {28'b0, key_event},   {28'b0, m_ev});
        check("io_read_data", bus.io_read_data,    model_read(a));
        @(posedge io_clk);
        model_edge({kn, sw}, a, ren);
        @(negedge io_clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(cur_sw, cur_kn, 32'h0, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr           = a;
        bus.read_io_enable = 1'b0;
        #1;
        check(tag, bus.io_read_data, exp);
    endtask

    initial begin
        logic [31:0] t0;
        logic [31:0] t1;
        logic [31:0] r;
        logic [31:0] a;
        logic        ren;

        clrn               = 1'b0;
        cur_sw             = 8'h00;
        cur_kn             = 4'hF;
        sw_raw             = cur_sw;
        key_raw_n          = cur_kn;
        bus.addr           = 32'h0;
        bus.read_io_enable = 1'b0;
        model_reset();
        repeat (3) @(posedge io_clk);
        @(negedge io_clk);
        check("rst_in_port",   {24'b0, in_port},     32'h0);
        check("rst_key_press", {28'b0, key_pressed}, 32'h0);
        check("rst_key_event", {28'b0, key_event},   32'h0);
        clrn = 1'b1;

        // 1: idle after reset, no spurious event
        idle(20);
        check("t1_no_event", {28'b0, key_event}, 32'h0);

        // 2: 0xA5 appears exactly DEB+2 edges later
        cur_sw = 8'hA5;
        idle(5);
        check("t2_not_yet", {24'b0, in_port}, 32'h0);
        idle(1);
        check("t2_latency", {24'b0, in_port}, 32'hA5);
        peek("t2_rd80", 32'h80, 32'h000000A5);

        // 3: 3-cycle glitch on sw[0] is filtered
        cur_sw = 8'hA4;
        idle(8);
        check("t3_settled", {24'b0, in_port}, 32'hA4);
        for (int i = 0; i < 11; i++) begin
            step((i < 3) ? 8'hA5 : 8'hA4, cur_kn, 32'h0, 1'b0);
            check("t3_glitch", {31'b0, in_port[0]}, 32'h0);
        end

        // 4: key2 bounces then holds
        for (int i = 0; i < 5; i++) step(cur_sw, (i % 2 == 0) ? 4'b1011 : 4'b1111, 32'h0, 1'b0);
        cur_kn = 4'b1011;
        idle(10);
        check("t4_pressed", {28'b0, key_pressed}, 32'h4);
        check("t4_event",   {28'b0, key_event},   32'h4);
        peek("t4_rd88_first", 32'h88, 32'h4);
        step(cur_sw, cur_kn, 32'h88, 1'b1);
        peek("t4_rd88_second", 32'h88, 32'h0);

        // 5: key1 press lands on the clearing edge
        cur_kn = 4'hF;
        idle(10);
        check("t5_release_no_event", {28'b0, key_event}, 32'h0);
        cur_kn = 4'b1011;
        idle(10);
        check("t5_event_k2", {28'b0, key_event}, 32'h4);
        cur_kn = 4'b1001;
        idle(5);
        peek("t5_rd_pre_clear", 32'h88, 32'h4);
        step(cur_sw, cur_kn, 32'h88, 1'b1);
        check("t5_set_beats_clear", {28'b0, key_event},   32'h2);
        check("t5_pressed",         {28'b0, key_pressed}, 32'h6);

        // 6: unmapped read, tick delta
        peek("t6_unmapped", 32'h90, 32'h0);
        bus.addr = 32'h8C;
        #1;
        t0 = bus.io_read_data;
        idle(7);
        bus.addr = 32'h8C;
        #1;
        t1 = bus.io_read_data;
        check("t6_tick_delta", t1 - t0, 32'd7);

        // Random phase
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 5) == 0) cur_sw = 8'($urandom);
            if ($urandom_range(0, 7) == 0) cur_kn = cur_kn ^ 4'(1 << $urandom_range(0, 3));
            ren = ($urandom_range(0, 3) == 0);
            r   = $urandom;
            case ($urandom_range(0, 5))
                0: a = {r[31:8], 8'h80};
                1: a = {r[31:8], 8'h84};
                2: a = {r[31:8], 8'h88};
                3: a = {r[31:8], 8'h8C};
                4: a = 32'h90;
                default: a = r;
            endcase
            step(cur_sw, cur_kn, a, ren);
        end

        // Asynchronous reset mid-cycle
        bus.addr           = 32'h8C;
        bus.read_io_enable = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        check("arst_in_port",   {24'b0, in_port},     32'h0);
        check("arst_key_press", {28'b0, key_pressed}, 32'h0);
        check("arst_key_event", {28'b0, key_event},   32'h0);
        check("arst_tick",      bus.io_read_data,     32'h0);
        repeat (2) @(posedge io_clk);
        @(negedge io_clk);
        clrn   = 1'b1;
        cur_sw = 8'h00;
        cur_kn = 4'hF;
        model_reset();
        idle(20);
        check("post_rst_no_event", {28'b0, key_event}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
